// File: rtl/param_bus_divider.sv
// Restoring divider fed and drained over a narrow bus: four-phase beat input,
// one quotient bit per cycle, pop-style beat output. Optional signed mode.
module param_bus_divider #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dataready,
  input  logic [BUS_W-1:0] Data_in,
  input  logic             sgn,
  input  logic             receiveData,
  output logic [BUS_W-1:0] Data_out,
  output logic             OutBuffFull,
  output logic             error,
  output logic             readyToAccept
);

  localparam int NB    = DATA_W / BUS_W;
  localparam int BEATS = 2 * NB;
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int ICW   = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0]    BEATS_C = BCW'(BEATS);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_FIX, S_OUT} state_t;
  state_t state, state_nxt;

  logic [2*DATA_W-1:0]       op_sr;
  logic [2*DATA_W-BUS_W-1:0] out_sr;
  logic [BCW-1:0]            beat_cnt, out_cnt;
  logic [ICW-1:0]            iter_cnt;
  logic                      armed, sgn_l, neg_q, neg_r, special;
  logic [DATA_W-1:0]         rem, quo, dvs;

  logic [DATA_W-1:0] dividend, divisor, q_fix, r_fix;
  logic [DATA_W:0]   shifted, diff;
  logic              loaded, capture, div_zero, ovf, neg_d, neg_v, pop, last_pop;

  assign dividend = op_sr[DATA_W-1:0];
  assign divisor  = op_sr[2*DATA_W-1:DATA_W];
  assign loaded   = (state == S_LOAD) && (beat_cnt == BEATS_C);
  assign capture  = (state == S_LOAD) && !loaded && dataready && armed;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn_l && (dividend == MIN_NEG) && (divisor == '1);
  assign neg_d    = sgn_l & dividend[DATA_W-1];
  assign neg_v    = sgn_l & divisor[DATA_W-1];
  assign pop      = (state == S_OUT) && receiveData && OutBuffFull;
  assign last_pop = pop && (out_cnt == BCW'(1));

  // The working partial remainder is one bit wider than the stored one; a
  // restored value is always below the divisor, so its top bit is zero.
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_fix = (!special && neg_q) ? -quo : quo;
  assign r_fix = (!special && neg_r) ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (loaded) state_nxt = (div_zero || ovf) ? S_FIX : S_CALC;
      S_CALC: if (iter_cnt == ICW'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_OUT;
      S_OUT:  if (last_pop) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_sr         <= '0;
      out_sr        <= '0;
      beat_cnt      <= '0;
      out_cnt       <= '0;
      iter_cnt      <= '0;
      armed         <= 1'b1;
      sgn_l         <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      special       <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      Data_out      <= '0;
      OutBuffFull   <= 1'b0;
      error         <= 1'b0;
      readyToAccept <= 1'b0;
    end else begin
      // Arming tracks dataready in every state so a beat held across an
      // operation is never taken twice, while a fresh one waits its turn.
      if (capture)         armed <= 1'b0;
      else if (!dataready) armed <= 1'b1;

      if (capture)                                     readyToAccept <= 1'b1;
      else if (!dataready || (state_nxt != S_LOAD))    readyToAccept <= 1'b0;

      case (state)
        S_LOAD: begin
          if (capture) begin
            op_sr    <= {Data_in, op_sr[2*DATA_W-1:BUS_W]};
            beat_cnt <= beat_cnt + BCW'(1);
            if (beat_cnt == '0) begin
              error <= 1'b0;
              sgn_l <= sgn;
            end
          end else if (loaded) begin
            beat_cnt <= '0;
            iter_cnt <= ICW'(DATA_W);
            special  <= div_zero || ovf;
            neg_q    <= neg_d ^ neg_v;
            neg_r    <= neg_d;
            rem      <= '0;
            if (div_zero) begin
              quo   <= '1;
              rem   <= dividend;
              error <= 1'b1;
            end else if (ovf) begin
              quo   <= MIN_NEG;
              error <= 1'b1;
            end else begin
              quo <= neg_d ? -dividend : dividend;
              dvs <= neg_v ? -divisor : divisor;
            end
          end
        end
        S_CALC: begin
          quo      <= {quo[DATA_W-2:0], ~diff[DATA_W]};
          rem      <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          iter_cnt <= iter_cnt - ICW'(1);
        end
        S_FIX: begin
          Data_out    <= q_fix[BUS_W-1:0];
          out_sr      <= {r_fix, q_fix[DATA_W-1:BUS_W]};
          out_cnt     <= BEATS_C;
          OutBuffFull <= 1'b1;
        end
        S_OUT: begin
          if (pop) begin
            if (out_cnt == BCW'(1)) begin
              OutBuffFull <= 1'b0;
            end else begin
              Data_out <= out_sr[BUS_W-1:0];
              out_sr   <= out_sr >> BUS_W;
              out_cnt  <= out_cnt - BCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
